// File: rtl/dnn_sigmoid_ulaw_core.sv
// rtl/dnn_sigmoid_ulaw_core.sv - two-layer u-law MLP (400-25-10) with sigmoid LUT in external memory
module dnn_sigmoid_ulaw_core #(
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A     = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W     = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT   = 16'h29be,
  parameter int                    SM1_SCALE       = 1,
  parameter int                    SM2_SCALE       = 1,
  parameter logic [7:0]            L2_ONE_BIAS_VAL = 8'b10001111,
  parameter int                    WIDTH_SIG_LUT   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reset,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [7:0]            mem_data,
  output logic signed [7:0]            out [10]
);

  localparam int unsigned L1_FAN = 401;    // 400 inputs + bias
  localparam int unsigned L2_OFF = 10025;  // 25 * 401 layer-1 weights
  localparam int unsigned L2_FAN = 26;     // 25 hidden + bias

  typedef enum logic [2:0] {
    S_IDLE, S_L1_A, S_L1_W, S_L1_LUT, S_L2_MAC, S_L2_ST, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [8:0]                idx_q, idx_d;     // L1 input index / L2 hidden index
  logic [4:0]                nrn_q, nrn_d;     // L1 hidden neuron / L2 output neuron
  logic signed [35:0]        acc_q, acc_d;
  logic [7:0]                a_q, a_d;         // latched input code for the L1 MAC
  logic                      done_q, done_d;
  logic [WIDTH_SIG_LUT-1:0]  h_q [25];
  logic signed [7:0]         out_q [10];

  logic                      h_we, out_we;
  logic [7:0]                op_code;
  logic [4:0]                hidx;
  logic signed [25:0]        prod;
  logic signed [7:0]         pre1, pre2;

  // sign/magnitude u-law code to signed linear value, magnitude 0..3952
  function automatic logic signed [12:0] ulaw_dec(input logic [7:0] c);
    logic [12:0] mag;
    mag = (13'({1'b1, c[3:0]}) << c[6:4]) - 13'd16;
    return c[7] ? signed'(mag) : -signed'(mag);
  endfunction

  // arithmetic scale-down of the accumulator, clamped to the signed byte range
  function automatic logic signed [7:0] sat_pre(input logic signed [35:0] a, input int sh);
    logic signed [35:0] s;
    s = a >>> sh;
    if (s > 36'sd127)       return 8'sd127;
    else if (s < -36'sd128) return -8'sd128;
    else                    return s[7:0];
  endfunction

  assign done = done_q;
  assign out  = out_q;

  // MAC operand selection and pre-activation of whatever the accumulator holds
  always_comb begin
    hidx    = (idx_q == 9'd0) ? 5'd0 : 5'(idx_q - 9'd1);
    op_code = (state_q == S_L2_MAC) ? ((idx_q == 9'd0) ? L2_ONE_BIAS_VAL : h_q[hidx]) : a_q;
    prod    = ulaw_dec(op_code) * ulaw_dec(mem_data);
    pre1    = sat_pre(acc_q, 8 + SM1_SCALE);
    pre2    = sat_pre(acc_q, 8 + SM2_SCALE);
  end

  // next-state, datapath next values and memory address
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nrn_d    = nrn_q;
    acc_d    = acc_q;
    a_d      = a_q;
    done_d   = (state_q == S_DONE);
    h_we     = 1'b0;
    out_we   = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        idx_d = '0;
        nrn_d = '0;
        if (start) state_d = S_L1_A;
      end
      S_L1_A: begin
        mem_addr = ADDR_BASE_A + ADDR_WIDTH'(idx_q);
        a_d      = mem_data;
        state_d  = S_L1_W;
      end
      S_L1_W: begin
        mem_addr = ADDR_BASE_W + ADDR_WIDTH'(32'(nrn_q) * L1_FAN + 32'(idx_q));
        acc_d    = acc_q + {{10{prod[25]}}, prod};
        if (idx_q == 9'd400) begin
          idx_d   = '0;
          state_d = S_L1_LUT;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = S_L1_A;
        end
      end
      S_L1_LUT: begin
        mem_addr = ADDR_BASE_LUT + ADDR_WIDTH'({~pre1[7], pre1[6:0]});
        h_we     = 1'b1;
        acc_d    = '0;
        if (nrn_q == 5'd24) begin
          nrn_d   = '0;
          state_d = S_L2_MAC;
        end else begin
          nrn_d   = nrn_q + 5'd1;
          state_d = S_L1_A;
        end
      end
      S_L2_MAC: begin
        mem_addr = ADDR_BASE_W + ADDR_WIDTH'(L2_OFF + 32'(nrn_q) * L2_FAN + 32'(idx_q));
        acc_d    = acc_q + {{10{prod[25]}}, prod};
        if (idx_q == 9'd25) begin
          idx_d   = '0;
          state_d = S_L2_ST;
        end else begin
          idx_d   = idx_q + 9'd1;
        end
      end
      S_L2_ST: begin
        out_we = 1'b1;
        acc_d  = '0;
        if (nrn_q == 5'd9) begin
          nrn_d   = '0;
          state_d = S_DONE;
        end else begin
          nrn_d   = nrn_q + 5'd1;
          state_d = S_L2_MAC;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // soft clear overrides everything, including a coincident start
    if (reset) begin
      state_d = S_IDLE;
      idx_d   = '0;
      nrn_d   = '0;
      acc_d   = '0;
      done_d  = 1'b0;
      h_we    = 1'b0;
      out_we  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // counters, accumulator, operand latch and done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      nrn_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      nrn_q  <= nrn_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      done_q <= done_d;
    end
  end

  // hidden-code and output-score register files; survive a soft clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 25; n++) h_q[n] <= '0;
      for (int n = 0; n < 10; n++) out_q[n] <= '0;
    end else begin
      if (h_we)   h_q[nrn_q] <= mem_data[WIDTH_SIG_LUT-1:0];
      if (out_we) out_q[nrn_q[3:0]] <= pre2;
    end
  end

endmodule

// File: tb/tb_dnn_sigmoid_ulaw_core.sv
// tb/tb_dnn_sigmoid_ulaw_core.sv - scoreboard bench for dnn_sigmoid_ulaw_core
module tb_dnn_sigmoid_ulaw_core;

  localparam int LAT   = 20346;
  localparam int A_W1  = 401;
  localparam int A_W2  = 10426;
  localparam int A_LUT = 10686;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              reset;
  logic              done;
  logic [15:0]       mem_addr;
  logic signed [7:0] mem_data;
  logic signed [7:0] out [10];

  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic [31:0]     done_cyc;
    logic [9:0][7:0] o;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  logic done_prev = 1'b0;
  exp_t m_e;

  dnn_sigmoid_ulaw_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reset    (reset),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out      (out)
  );

  assign mem_data = signed'(mem[mem_addr]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int w1(input int j, input int i);
    return A_W1 + j * 401 + i;
  endfunction

  function automatic int w2(input int k, input int j);
    return A_W2 + k * 26 + j;
  endfunction

  // monitor: every rising done pops one expected result
  always @(negedge clk) begin
    if (done && !done_prev) begin
      chk("done_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        m_e = sb_q.pop_front();
        chk("done_latency", cyc, int'(m_e.done_cyc));
        for (int k = 0; k < 10; k++)
          chk($sformatf("out[%0d]", k), int'(out[k]), int'($signed(m_e.o[k])));
      end
    end
    done_prev = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mem_base(input logic [7:0] a_code, input logic [7:0] lut_code);
    for (int a = 0; a < 65536; a++) mem[a] = 8'h80;
    for (int i = 0; i < 401; i++) mem[i] = a_code;
    for (int x = 0; x < 256; x++) mem[A_LUT + x] = lut_code;
  endtask

  task automatic launch(input logic [9:0][7:0] o, input int hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.done_cyc = 32'(cyc + 1 + LAT);
    e.o = o;
    sb_q.push_back(e);
    tick(hold);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic soft_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_done_low", int'(done), 0);
    chk("reset_addr_idle", int'(mem_addr), 0);
  endtask

  task automatic config_b();
    mem_base(8'h80, 8'h8F);
    mem[0]           = 8'h8F;
    mem[1]           = 8'hFF;
    mem[w1(0, 0)]    = 8'hFF;   // pre 115 -> LUT 243
    mem[w1(1, 1)]    = 8'h7F;   // saturates to -128 -> LUT 0
    mem[A_LUT + 243] = 8'hFF;
    mem[A_LUT + 0]   = 8'hFF;
    mem[w2(3, 0)]    = 8'hFF;   // bias 15 * 3952 -> 115
    mem[w2(5, 1)]    = 8'h8F;   // 15 * h0 -> 115
    mem[w2(2, 2)]    = 8'hFF;   // 3952 * 3952 -> 127
    mem[w2(7, 2)]    = 8'h7F;   // -> -128
  endtask

  initial begin
    logic [9:0][7:0] eo;
    rst   = 1'b1;
    start = 1'b0;
    reset = 1'b0;
    mem_base(8'hC5, 8'h80);
    #12;
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_out0", int'(out[0]), 0);
    chk("rst_out9", int'(out[9]), 0);
    @(negedge clk);
    rst = 1'b0;

    // run A: all weights zero
    eo = '0;
    launch(eo, 1);
    wait_done(LAT + 100);
    tick(5);
    chk("done_hold", int'(done), 1);
    chk("done_addr", int'(mem_addr), 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(2);
    chk("start_in_done", int'(done), 1);
    soft_reset();

    // run B: bias, layer-1 LUT path and saturation
    config_b();
    eo = '0;
    eo[3] = 8'd115;
    eo[5] = 8'd115;
    eo[2] = 8'd127;
    eo[7] = 8'h80;
    launch(eo, 1);
    wait_done(LAT + 100);
    soft_reset();

    // asynchronous reset mid layer 1, away from any clock edge
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(100);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done", int'(done), 0);
    chk("arst_addr", int'(mem_addr), 0);
    chk("arst_out2", int'(out[2]), 0);
    chk("arst_out3", int'(out[3]), 0);
    chk("arst_out7", int'(out[7]), 0);
    @(negedge clk);
    rst = 1'b0;

    // abort at cycle 5000 with a coincident start; extra start while busy
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(4948);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("abort_done", int'(done), 0);
    chk("abort_addr", int'(mem_addr), 0);
    tick(200);
    chk("abort_stays_idle", int'(mem_addr), 0);
    chk("abort_no_done", int'(done), 0);

    // run C: start held, re-pulsed mid run; negative floor and hidden index 2
    config_b();
    mem[w2(3, 0)] = 8'h7F;      // -59280 >>> 9 = -116
    mem[w2(0, 3)] = 8'hFF;      // 3952 * h2 (15) -> 115
    eo = '0;
    eo[0] = 8'd115;
    eo[3] = 8'h8C;
    eo[5] = 8'd115;
    eo[2] = 8'd127;
    eo[7] = 8'h80;
    launch(eo, 3);
    tick(15000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT);
    soft_reset();

    tick(3);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
